// File: rtl/fetch_requester.sv
// fetch_requester: initiator side of the CPU memory interface.
// Issues instruction fetches from the program counter, holds mem_op/mem_addr
// stable across the synchronous RAM read latency, captures the returned word
// and offers it to decode through a valid/ready handshake. Redirects from
// execute (branch/jump targets) reload the PC and abandon any in-flight or
// pending instruction.
module fetch_requester #(
  parameter logic [31:0] RESET_PC     = 32'h0000_0000,
  parameter int unsigned READ_LATENCY = 2,      // legal range 1..15
  parameter logic [7:0]  MEM_FETCH    = 8'd1,
  parameter logic [7:0]  MEM_NOP      = 8'd0
) (
  input  logic        clk,
  input  logic        rst,
  output logic [31:0] mem_addr,
  output logic [7:0]  mem_op,
  output logic [31:0] mem_data_in,
  input  logic [31:0] mem_data_out,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_target,
  output logic [31:0] instr,
  output logic [31:0] instr_pc,
  output logic        instr_valid,
  input  logic        instr_ready
);

  typedef enum logic [1:0] {
    ST_IDLE,   // one cycle after reset release before the first request
    ST_REQ,    // request on the bus, counting out the read latency
    ST_VALID   // instruction offered to decode, bus idle
  } state_t;

  // Counter value on the edge where the returned word is valid.
  localparam logic [3:0]  LAST_CNT = 4'(READ_LATENCY - 1);
  // Instructions are word aligned; the two low PC bits are always zero.
  localparam logic [31:0] ALIGN_MASK = ~32'h0000_0003;

  state_t      state, state_nxt;
  logic [31:0] pc, pc_nxt;
  logic [3:0]  cnt, cnt_nxt;
  logic [31:0] mem_addr_nxt;
  logic [7:0]  mem_op_nxt;
  logic [31:0] instr_nxt;
  logic [31:0] instr_pc_nxt;
  logic        instr_valid_nxt;

  logic [31:0] target_aligned;
  logic        last_beat;
  logic        handshake;

  // Fetch-only requester: never writes memory.
  assign mem_data_in    = 32'd0;

  assign target_aligned = redirect_target & ALIGN_MASK;
  assign last_beat      = (cnt == LAST_CNT);
  assign handshake      = instr_valid & instr_ready;

  // State and every output register; reset is asynchronous and immediate.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= ST_IDLE;
      pc          <= RESET_PC & ALIGN_MASK;
      cnt         <= 4'd0;
      mem_addr    <= 32'd0;
      mem_op      <= MEM_NOP;
      instr       <= 32'd0;
      instr_pc    <= 32'd0;
      instr_valid <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every register samples the values
      // from before this edge, independent of statement order.
      state       <= state_nxt;
      pc          <= pc_nxt;
      cnt         <= cnt_nxt;
      mem_addr    <= mem_addr_nxt;
      mem_op      <= mem_op_nxt;
      instr       <= instr_nxt;
      instr_pc    <= instr_pc_nxt;
      instr_valid <= instr_valid_nxt;
    end
  end

  // Next-state and next-output logic; redirect outranks every other event.
  always_comb begin
    // NOTE: every signal gets a hold-value default first, so no path through
    // the case statement can leave one unassigned and infer a latch.
    state_nxt       = state;
    pc_nxt          = pc;
    cnt_nxt         = cnt;
    mem_addr_nxt    = mem_addr;
    mem_op_nxt      = mem_op;
    instr_nxt       = instr;
    instr_pc_nxt    = instr_pc;
    instr_valid_nxt = instr_valid;

    unique case (state)
      ST_IDLE: begin
        // A redirect arriving here replaces the reset PC for the first fetch.
        state_nxt  = ST_REQ;
        mem_op_nxt = MEM_FETCH;
        cnt_nxt    = 4'd0;
        if (redirect_valid) begin
          pc_nxt       = target_aligned;
          mem_addr_nxt = target_aligned;
        end else begin
          mem_addr_nxt = pc;
        end
      end

      ST_REQ: begin
        if (redirect_valid) begin
          // Abandon the in-flight read and restart the latency count at
          // the new address; mem_op remains MEM_FETCH.
          pc_nxt       = target_aligned;
          mem_addr_nxt = target_aligned;
          cnt_nxt      = 4'd0;
        end else if (last_beat) begin
          // Read data is valid on this edge: capture it and free the bus.
          instr_nxt       = mem_data_out;
          instr_pc_nxt    = pc;
          instr_valid_nxt = 1'b1;
          pc_nxt          = pc + 32'd4;   // modulo 2^32, wraps silently
          mem_op_nxt      = MEM_NOP;
          cnt_nxt         = 4'd0;
          state_nxt       = ST_VALID;
        end else begin
          cnt_nxt = cnt + 4'd1;
        end
      end

      ST_VALID: begin
        if (redirect_valid) begin
          // The offered instruction is dropped even if decode accepts it
          // on this same edge.
          instr_valid_nxt = 1'b0;
          pc_nxt          = target_aligned;
          mem_addr_nxt    = target_aligned;
          mem_op_nxt      = MEM_FETCH;
          cnt_nxt         = 4'd0;
          state_nxt       = ST_REQ;
        end else if (handshake) begin
          instr_valid_nxt = 1'b0;
          mem_addr_nxt    = pc;
          mem_op_nxt      = MEM_FETCH;
          cnt_nxt         = 4'd0;
          state_nxt       = ST_REQ;
        end
      end

      default: begin
        state_nxt = ST_IDLE;
      end
    endcase
  end

endmodule

// File: doc/fetch_requester.md
Name: fetch_requester

Overview:
- Initiator side of the CPU memory interface: generates mem_op/mem_addr fetch requests toward the system memory block, waits out the synchronous RAM read latency, captures the returned word, and hands instructions to decode with a valid/ready handshake.
- Owns the program counter; accepts redirects (branch/jump targets) from execute.
- The memory block muxes read data combinationally on mem_op, so mem_op and mem_addr are held stable for the whole read latency.

Parameters:
- RESET_PC, 32'h0000_0000, byte address fetched first after reset.
- READ_LATENCY, 2, cycles from request presentation to valid mem_data_out (1..15).
- MEM_FETCH, 8'd1, mem_op encoding for an instruction fetch.
- MEM_NOP, 8'd0, mem_op encoding for no operation.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- mem_addr  out  32  byte address to memory (registered).
- mem_op  out  8  memory operation code (registered).
- mem_data_in  out  32  write data to memory; tied 32'd0 (fetch-only).
- mem_data_out  in  32  read data returned by memory.
- redirect_valid  in  1  one-cycle pulse: load new PC.
- redirect_target  in  32  new PC byte address.
- instr  out  32  captured instruction word.
- instr_pc  out  32  byte address instr was fetched from.
- instr_valid  out  1  instr/instr_pc valid.
- instr_ready  in  1  decode accepts instr this cycle.

Behaviour:
- Reset (async, immediate): state=IDLE, pc=RESET_PC with [1:0] forced 00, mem_op=MEM_NOP, mem_addr=0, instr=0, instr_pc=0, instr_valid=0, cnt=0.
- All outputs are registered. No combinational path from inputs to outputs.
- IDLE: first edge after rst deasserts -> REQ. mem_op<=MEM_FETCH, mem_addr<=pc, cnt<=0.
- REQ: mem_op=MEM_FETCH and mem_addr=pc are held constant. cnt increments each cycle.
  - At the edge where cnt==READ_LATENCY-1: instr<=mem_data_out, instr_pc<=pc, instr_valid<=1, pc<=pc+4, mem_op<=MEM_NOP, cnt<=0 -> VALID.
  - Capture occurs READ_LATENCY cycles after mem_op first shows MEM_FETCH.
- VALID: instr, instr_pc and instr_valid are held.
  - On an edge with instr_valid & instr_ready: instr_valid<=0, mem_op<=MEM_FETCH, mem_addr<=pc -> REQ.
  - Steady throughput is one instruction per READ_LATENCY+1 cycles.
  - instr_ready low stalls indefinitely; no new request is issued while stalled.
- Redirect (highest priority, any non-reset state):
  - pc<=redirect_target & ~32'h3 (misaligned targets silently aligned).
  - In REQ: the in-flight read is discarded, mem_addr<=aligned target, cnt<=0, stay in REQ; mem_op stays MEM_FETCH.
  - In VALID: instr_valid<=0 even if instr_ready is high the same cycle (handshake void, instruction dropped); mem_op<=MEM_FETCH, mem_addr<=aligned target -> REQ.
  - In IDLE: the target replaces RESET_PC for the first fetch.
- pc arithmetic is 32-bit modulo: 32'hFFFF_FFFC+4 wraps to 0 with no flag.
- mem_data_in is constant 0.
- mem_op takes only the values MEM_NOP and MEM_FETCH.
- Reset mid-REQ aborts immediately. The next fetch after release is RESET_PC.

Test Plan:
- Reset/startup: assert rst, check all outputs at reset values; release with a latency-2 memory model holding word[i]=32'hA000_0000+i, instr_ready=1 -> mem_addr sequence 0,4,8 with mem_op=1 for exactly 2 cycles each; instr=A0000000,A0000001,A0000002 with instr_pc=0,4,8; instr_valid high one cycle in every 3.
- Backpressure: hold instr_ready=0 for 10 cycles after the first instr_valid -> instr and instr_pc stable, mem_op=0 throughout; raise ready -> next request addr 4 on the following cycle.
- Redirect during REQ: redirect_target=32'h100 on the 1st REQ cycle of the fetch at addr 8 -> mem_addr switches to 0x100; next instr_pc=0x100, instr=word[0x40]; the addr-8 word never appears.
- Redirect in VALID with instr_ready=1 the same cycle, redirect_target=32'h203 -> instruction dropped, next mem_addr=0x200, instr_pc=0x200.
- Async reset mid-REQ, plus wrap: pulse rst asynchronously between edges -> outputs clear without a clock edge; refetch from RESET_PC. Redirect to 32'hFFFF_FFFC -> next fetch address 0.
- READ_LATENCY=1 and 4 configurations -> mem_op held for exactly 1 and 4 cycles per fetch; captured data correct.
